fixed_point_accumulator: RTL

- Sequential stage directly downstream of the ODE solver's fixed-point multiplier; consumes its 16-bit products as a valid/ready stream.
- Sums one packet of terms (packet end marked by in_last), then renormalises the sum back to the shared 16-bit format.
- Word format: bits 15:3 are a signed 13-bit mantissa; bits 2:0 are an unsigned scale s. Value = mantissa / 2^s.
- Output feeds the state-update adder of the solver.

---
 rtl/fixed_point_accumulator.sv | 108 ++++++++++
 1 files changed

// File: rtl/fixed_point_accumulator.sv
// rtl/fixed_point_accumulator.sv - packet accumulator with renormalisation to 13-bit mantissa / 3-bit scale words
module fixed_point_accumulator #(
  parameter int ACC_W = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        overflow
);

  typedef enum logic [1:0] {ACCUM, NORM, OUT} state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t                  state;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] work;
  logic [2:0]              sc;

  logic signed [12:0]      mant;
  logic [2:0]              s_in;
  logic signed [ACC_W:0]   aligned;
  logic signed [ACC_W:0]   sum;
  logic signed [ACC_W-1:0] clamped;
  logic                    clamp_hit;
  logic                    work_fits;

  assign mant = in_data[15:3];
  assign s_in = in_data[2:0];

  // Every term is brought to internal scale 7 before summing; one guard bit catches overflow.
  always_comb begin
    aligned   = {{(ACC_W-12){mant[12]}}, mant} <<< (3'd7 - s_in);
    sum       = {acc[ACC_W-1], acc} + aligned;
    clamp_hit = sum[ACC_W] != sum[ACC_W-1];
    clamped   = sum[ACC_W-1:0];
    if (clamp_hit) begin
      clamped = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  // Fits the 13-bit mantissa when all bits above bit 12 replicate the sign.
  assign work_fits = (work[ACC_W-1:12] == '0) || (work[ACC_W-1:12] == '1);

  assign in_ready = rst_n && (state == ACCUM) && !clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      acc       <= '0;
      work      <= '0;
      sc        <= 3'd0;
      out_valid <= 1'b0;
      out_data  <= 16'h0000;
      overflow  <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (clr) begin
            acc      <= '0;
            overflow <= 1'b0;
          end else if (in_valid) begin
            acc <= clamped;
            if (clamp_hit) overflow <= 1'b1;
            if (in_last) begin
              work  <= clamped;
              sc    <= 3'd7;
              state <= NORM;
            end
          end
        end
        NORM: begin
          if (work_fits) begin
            out_data  <= {work[12:0], sc};
            out_valid <= 1'b1;
            state     <= OUT;
          end else if (sc == 3'd0) begin
            out_data  <= work[ACC_W-1] ? 16'h8000 : 16'h7FF8;
            overflow  <= 1'b1;
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            work <= work >>> 1;
            sc   <= sc - 3'd1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            overflow  <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
